// File: rtl/moore_seq_checker.sv
// moore_seq_checker: receive-side checker for the 3-bit free-running Moore
// sequence generator. It samples {in0,in1,in2} on every enabled edge and
// expects the code to advance by +1 mod 8. The FSM acquires lock after
// LOCK_CNT good transitions and drops it after UNLOCK_CNT consecutive bad
// transitions. It also counts errors (saturating) and wraps (modulo), and
// mirrors the generator's all-ones flag.
//
// Optional build macro: MOORE_SEQ_CHECKER_STICKY_EN
//   When defined, the err_sticky output is added. It is set on any error
//   pulse or on any bad transition in SYNC, and is cleared only by rst_n.
module moore_seq_checker #(
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 2,
    parameter int ERR_W      = 8,
    parameter int WRAP_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in0,
    input  logic              in1,
    input  logic              in2,
    output logic              locked,
    output logic              all_ones,
    output logic              wrap_pulse,
    output logic              err_pulse,
    output logic              lost_lock,
    output logic [ERR_W-1:0]  err_cnt,
`ifdef MOORE_SEQ_CHECKER_STICKY_EN
    output logic              err_sticky,
`endif
    output logic [WRAP_W-1:0] wrap_cnt
);

    localparam logic [2:0] LOCK_THR   = 3'(LOCK_CNT);
    localparam logic [2:0] UNLOCK_THR = 3'(UNLOCK_CNT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HUNT,
        ST_SYNC,
        ST_LOCKED
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [2:0]        r_prev_code;
    logic [2:0]        r_run;
    logic [2:0]        w_run_next;
    logic [2:0]        r_miss;
    logic [2:0]        w_miss_next;
    logic [2:0]        w_cur;
    logic              w_good;
    logic              w_err;
    logic              w_lost;
    logic              w_wrap;
    logic              w_sync_bad;
    logic              r_all_ones;
    logic              r_wrap_pulse;
    logic              r_err_pulse;
    logic              r_lost_lock;
    logic [ERR_W-1:0]  r_err_cnt;
    logic [WRAP_W-1:0] r_wrap_cnt;

    assign w_cur  = {in0, in1, in2};
    // 3-bit addition wraps naturally, so 7 -> 0 counts as good.
    assign w_good = (w_cur == (r_prev_code + 3'd1));

    // Next-state logic and event decoding for the lock FSM.
    always_comb begin
        w_state_next = r_state;
        w_run_next   = r_run;
        w_miss_next  = r_miss;
        w_err        = 1'b0;
        w_lost       = 1'b0;
        w_wrap       = 1'b0;
        w_sync_bad   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // No predecessor yet: just capture the first code.
                w_state_next = ST_HUNT;
            end
            ST_HUNT: begin
                if (w_good) begin
                    if (LOCK_THR == 3'd1) begin
                        w_state_next = ST_LOCKED;
                        w_run_next   = 3'd0;
                    end else begin
                        w_state_next = ST_SYNC;
                        w_run_next   = 3'd1;
                    end
                end
            end
            ST_SYNC: begin
                if (w_good) begin
                    if ((r_run + 3'd1) == LOCK_THR) begin
                        w_state_next = ST_LOCKED;
                        w_run_next   = 3'd0;
                    end else begin
                        w_run_next = r_run + 3'd1;
                    end
                end else begin
                    w_state_next = ST_HUNT;
                    w_run_next   = 3'd0;
                    w_sync_bad   = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (w_good) begin
                    w_miss_next = 3'd0;
                    w_wrap      = (r_prev_code == 3'd7);
                end else begin
                    w_err = 1'b1;
                    if ((r_miss + 3'd1) == UNLOCK_THR) begin
                        w_lost       = 1'b1;
                        w_miss_next  = 3'd0;
                        w_state_next = ST_HUNT;
                    end else begin
                        w_miss_next = r_miss + 3'd1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register; it only advances on enabled edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else if (en) begin
            r_state <= w_state_next;
        end
    end

    // Previous code and run/miss counters. A bad code also becomes the new
    // reference, so the next expected value is cur+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_code <= 3'd0;
            r_run       <= 3'd0;
            r_miss      <= 3'd0;
        end else if (en) begin
            r_prev_code <= w_cur;
            r_run       <= w_run_next;
            r_miss      <= w_miss_next;
        end
    end

    // Registered flags and pulses; pulses are forced low on idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_all_ones   <= 1'b0;
            r_wrap_pulse <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_lost_lock  <= 1'b0;
        end else begin
            r_wrap_pulse <= en & w_wrap;
            r_err_pulse  <= en & w_err;
            r_lost_lock  <= en & w_lost;
            if (en) begin
                r_all_ones <= (w_cur == 3'd7);
            end
        end
    end

    // Error counter saturates at all-ones; wrap counter rolls over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt  <= '0;
            r_wrap_cnt <= '0;
        end else if (en) begin
            if (w_err && (r_err_cnt != {ERR_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
            if (w_wrap) begin
                r_wrap_cnt <= r_wrap_cnt + WRAP_W'(1);
            end
        end
    end

`ifdef MOORE_SEQ_CHECKER_STICKY_EN
    logic r_err_sticky;

    // Sticky error flag: set by any locked error or SYNC failure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_sticky <= 1'b0;
        end else if (en && (w_err || w_sync_bad)) begin
            r_err_sticky <= 1'b1;
        end
    end

    assign err_sticky = r_err_sticky;
`else
    logic w_sticky_unused;
    assign w_sticky_unused = w_sync_bad;
`endif

    assign locked     = (r_state == ST_LOCKED);
    assign all_ones   = r_all_ones;
    assign wrap_pulse = r_wrap_pulse;
    assign err_pulse  = r_err_pulse;
    assign lost_lock  = r_lost_lock;
    assign err_cnt    = r_err_cnt;
    assign wrap_cnt   = r_wrap_cnt;

endmodule

// File: tb/tb_moore_seq_checker.sv
// Testbench for moore_seq_checker: table-driven lock/wrap/error/unlock
// vectors, then hand-written sequences for error-count saturation (on a
// second instance with ERR_W=2), enable hold and asynchronous reset.
module tb_moore_seq_checker;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       in0;
    logic       in1;
    logic       in2;

    logic       locked;
    logic       all_ones;
    logic       wrap_pulse;
    logic       err_pulse;
    logic       lost_lock;
    logic [7:0] err_cnt;
    logic [7:0] wrap_cnt;

    logic       locked2;
    logic       all_ones2;
    logic       wrap_pulse2;
    logic       err_pulse2;
    logic       lost_lock2;
    logic [1:0] err_cnt2;
    logic [7:0] wrap_cnt2;

`ifdef MOORE_SEQ_CHECKER_STICKY_EN
    logic       err_sticky;
    logic       err_sticky2;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    moore_seq_checker #(
        .LOCK_CNT(3), .UNLOCK_CNT(2), .ERR_W(8), .WRAP_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .in0(in0), .in1(in1), .in2(in2),
        .locked(locked), .all_ones(all_ones), .wrap_pulse(wrap_pulse),
        .err_pulse(err_pulse), .lost_lock(lost_lock), .err_cnt(err_cnt),
`ifdef MOORE_SEQ_CHECKER_STICKY_EN
        .err_sticky(err_sticky),
`endif
        .wrap_cnt(wrap_cnt)
    );

    moore_seq_checker #(
        .LOCK_CNT(3), .UNLOCK_CNT(2), .ERR_W(2), .WRAP_W(8)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .in0(in0), .in1(in1), .in2(in2),
        .locked(locked2), .all_ones(all_ones2), .wrap_pulse(wrap_pulse2),
        .err_pulse(err_pulse2), .lost_lock(lost_lock2), .err_cnt(err_cnt2),
`ifdef MOORE_SEQ_CHECKER_STICKY_EN
        .err_sticky(err_sticky2),
`endif
        .wrap_cnt(wrap_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] code;
        logic       lk;
        logic       ao;
        logic       wp;
        logic       ep;
        logic       ll;
        int         ec;
        int         wc;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(input int code, input int lk, input int ao,
                                input int wp, input int ep, input int ll,
                                input int ec, input int wc);
        vec_t v;
        v.code = 3'(code);
        v.lk   = lk[0];
        v.ao   = ao[0];
        v.wp   = wp[0];
        v.ep   = ep[0];
        v.ll   = ll[0];
        v.ec   = ec;
        v.wc   = wc;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one sample, let one edge pass, sample outputs 1 time unit later.
    task automatic step(input logic e, input logic [2:0] code);
        en  = e;
        {in0, in1, in2} = code;
        @(posedge clk);
        #1;
        $display("t=%0t en=%0d code=%0d locked=%0d all_ones=%0d wrap=%0d err=%0d lost=%0d err_cnt=%0d wrap_cnt=%0d err_cnt2=%0d",
                 $time, e, code, locked, all_ones, wrap_pulse, err_pulse,
                 lost_lock, err_cnt, wrap_cnt, err_cnt2);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"},   int'(locked),     0);
        check({tag, "_all_ones"}, int'(all_ones),   0);
        check({tag, "_wrap"},     int'(wrap_pulse), 0);
        check({tag, "_err"},      int'(err_pulse),  0);
        check({tag, "_lost"},     int'(lost_lock),  0);
        check({tag, "_err_cnt"},  int'(err_cnt),    0);
        check({tag, "_wrap_cnt"}, int'(wrap_cnt),   0);
        check({tag, "_err_cnt2"}, int'(err_cnt2),   0);
        check({tag, "_locked2"},  int'(locked2),    0);
    endtask

    initial begin
        //               code lk ao wp ep ll ec wc
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0);  // IDLE -> HUNT
        vecs[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0);  // good 1
        vecs[2]  = mk(2, 0, 0, 0, 0, 0, 0, 0);  // good 2
        vecs[3]  = mk(3, 1, 0, 0, 0, 0, 0, 0);  // good 3 -> LOCKED
        vecs[4]  = mk(4, 1, 0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(5, 1, 0, 0, 0, 0, 0, 0);
        vecs[6]  = mk(6, 1, 0, 0, 0, 0, 0, 0);
        vecs[7]  = mk(7, 1, 1, 0, 0, 0, 0, 0);  // all_ones
        vecs[8]  = mk(0, 1, 0, 1, 0, 0, 0, 1);  // wrap
        vecs[9]  = mk(1, 1, 0, 0, 0, 0, 0, 1);
        vecs[10] = mk(2, 1, 0, 0, 0, 0, 0, 1);
        vecs[11] = mk(3, 1, 0, 0, 0, 0, 0, 1);
        vecs[12] = mk(5, 1, 0, 0, 1, 0, 1, 1);  // bad, single miss
        vecs[13] = mk(6, 1, 0, 0, 0, 0, 1, 1);  // good, miss clears
        vecs[14] = mk(7, 1, 1, 0, 0, 0, 1, 1);
        vecs[15] = mk(0, 1, 0, 1, 0, 0, 1, 2);  // wrap
        vecs[16] = mk(1, 1, 0, 0, 0, 0, 1, 2);
        vecs[17] = mk(2, 1, 0, 0, 0, 0, 1, 2);
        vecs[18] = mk(3, 1, 0, 0, 0, 0, 1, 2);
        vecs[19] = mk(6, 1, 0, 0, 1, 0, 2, 2);  // bad, miss 1
        vecs[20] = mk(2, 0, 0, 0, 1, 1, 3, 2);  // bad, miss 2 -> lost
        vecs[21] = mk(3, 0, 0, 0, 0, 0, 3, 2);  // HUNT -> SYNC
        vecs[22] = mk(4, 0, 0, 0, 0, 0, 3, 2);
        vecs[23] = mk(5, 1, 0, 0, 0, 0, 3, 2);  // re-locked

        rst_n = 1'b0;
        en    = 1'b0;
        {in0, in1, in2} = 3'd0;
        #23;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            int sat;
            step(1'b1, vecs[i].code);
            sat = (vecs[i].ec > 3) ? 3 : vecs[i].ec;
            check($sformatf("v%0d_locked", i),   int'(locked),     int'(vecs[i].lk));
            check($sformatf("v%0d_all_ones", i), int'(all_ones),   int'(vecs[i].ao));
            check($sformatf("v%0d_wrap", i),     int'(wrap_pulse), int'(vecs[i].wp));
            check($sformatf("v%0d_err", i),      int'(err_pulse),  int'(vecs[i].ep));
            check($sformatf("v%0d_lost", i),     int'(lost_lock),  int'(vecs[i].ll));
            check($sformatf("v%0d_err_cnt", i),  int'(err_cnt),    vecs[i].ec);
            check($sformatf("v%0d_wrap_cnt", i), int'(wrap_cnt),   vecs[i].wc);
            check($sformatf("v%0d_err_cnt2", i), int'(err_cnt2),   sat);
        end

        // Fresh start for the saturation sequence.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst2");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 3'(c));
        end
        check("sat_locked_init",  int'(locked),  1);
        check("sat_locked2_init", int'(locked2), 1);

        begin
            logic [2:0] bad_codes [5];
            logic [2:0] good_codes[5];
            int         exp2      [5];
            bad_codes  = '{3'd5, 3'd0, 3'd3, 3'd6, 3'd1};
            good_codes = '{3'd6, 3'd1, 3'd4, 3'd7, 3'd2};
            exp2       = '{1, 2, 3, 3, 3};
            for (int i = 0; i < 5; i++) begin
                step(1'b1, bad_codes[i]);
                check($sformatf("sat%0d_err_cnt2", i), int'(err_cnt2),  exp2[i]);
                check($sformatf("sat%0d_err_cnt", i),  int'(err_cnt),   i + 1);
                check($sformatf("sat%0d_err", i),      int'(err_pulse), 1);
                check($sformatf("sat%0d_locked", i),   int'(locked2),   1);
                step(1'b1, good_codes[i]);
                check($sformatf("sat%0d_good_err", i),    int'(err_pulse), 0);
                check($sformatf("sat%0d_good_locked", i), int'(locked),    1);
            end
        end

        for (int c = 3; c < 8; c++) begin
            step(1'b1, 3'(c));
        end
        check("pre_hold_all_ones", int'(all_ones), 1);
        check("pre_hold_wrap_cnt", int'(wrap_cnt), 0);

        // Enable low: inputs wander, nothing may change or pulse.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 3'($urandom_range(0, 7)));
            check($sformatf("hold%0d_locked", i),   int'(locked),     1);
            check($sformatf("hold%0d_all_ones", i), int'(all_ones),   1);
            check($sformatf("hold%0d_wrap", i),     int'(wrap_pulse), 0);
            check($sformatf("hold%0d_err", i),      int'(err_pulse),  0);
            check($sformatf("hold%0d_lost", i),     int'(lost_lock),  0);
            check($sformatf("hold%0d_err_cnt", i),  int'(err_cnt),    5);
            check($sformatf("hold%0d_err_cnt2", i), int'(err_cnt2),   3);
            check($sformatf("hold%0d_wrap_cnt", i), int'(wrap_cnt),   0);
        end

        // Held reference is still 7, so 0 must count as a wrap.
        step(1'b1, 3'd0);
        check("resume_wrap",     int'(wrap_pulse), 1);
        check("resume_wrap_cnt", int'(wrap_cnt),   1);
        check("resume_all_ones", int'(all_ones),   0);
        check("resume_err",      int'(err_pulse),  0);
        check("resume_locked",   int'(locked),     1);

        // Asynchronous reset in the middle of the high phase.
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
